// File: rtl/sdram_avl_arbiter_if.sv
// Avalon-MM burst port bundle shared by the arbiter's two requester ports and its SDRAM-side port.
// A command transfers on a clock edge where read or write is high and wait_request is low.
// A read beat transfers on every edge where read_data_valid is high; it cannot be stalled.
interface sdram_avl_arbiter_if #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 5
) ();
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W/8-1:0] byte_enable;
    logic [BURST_W-1:0]  burst_count;
    logic [DATA_W-1:0]   read_data;
    logic                read_data_valid;
    logic                wait_request;

    modport master (
        output address, read, write, write_data, byte_enable, burst_count,
        input  read_data, read_data_valid, wait_request
    );

    modport slave (
        input  address, read, write, write_data, byte_enable, burst_count,
        output read_data, read_data_valid, wait_request
    );
endinterface

// File: rtl/sdram_avl_arbiter.sv
// Two-master Avalon-MM burst arbiter in front of one SDRAM controller port.
// Round-robin grant per complete burst; read beats are routed only to the owning master.
module sdram_avl_arbiter #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_avl_arbiter_if.slave    m0,
    sdram_avl_arbiter_if.slave    m1,
    sdram_avl_arbiter_if.master   s,
    output logic [1:0]            owner,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_CMD  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    localparam logic [BURST_W:0]   CNT_ONE = (BURST_W + 1)'(1);
    localparam logic [BURST_W-1:0] BC_ONE  = BURST_W'(1);

    state_t             state_q, state_d;
    logic               owner_q, owner_d;   // 0 = M0, 1 = M1
    logic               last_q, last_d;     // master granted by the last completed burst
    logic [BURST_W:0]   cnt_q, cnt_d;

    logic               req0, req1;
    logic               pick;
    logic               pick_write;
    logic [BURST_W-1:0] pick_bc;
    logic [BURST_W-1:0] sel_bc;
    logic               sel_read, sel_write;
    logic               s_read, s_write;
    logic               fwd_phase;
    logic               rd_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req0      = m0.read | m0.write;
    assign req1      = m1.read | m1.write;
    assign sel_read  = owner_q ? m1.read  : m0.read;
    assign sel_write = owner_q ? m1.write : m0.write;
    assign sel_bc    = owner_q ? m1.burst_count : m0.burst_count;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        s_read     = 1'b0;
        s_write    = 1'b0;
        pick       = 1'b0;
        pick_write = 1'b0;
        pick_bc    = '0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the master that did not own the previous burst wins.
                    pick       = (req0 && req1) ? ~last_q : req1;
                    pick_write = pick ? m1.write : m0.write;
                    pick_bc    = pick ? m1.burst_count : m0.burst_count;
                    owner_d    = pick;
                    cnt_d      = (pick_bc == '0) ? CNT_ONE : {1'b0, pick_bc};
                    state_d    = pick_write ? WRITE : RD_CMD;
                end
            end
            WRITE: begin
                s_write = sel_write;
                if (s_write && !s.wait_request) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            RD_CMD: begin
                s_read = sel_read;
                if (s_read && !s.wait_request) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (s.read_data_valid) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fwd_phase = (state_q == WRITE) || (state_q == RD_CMD);
    assign rd_phase  = (state_q == RD_CMD) || (state_q == RD_WAIT);

    assign s.address     = owner_q ? m1.address     : m0.address;
    assign s.write_data  = owner_q ? m1.write_data  : m0.write_data;
    assign s.byte_enable = owner_q ? m1.byte_enable : m0.byte_enable;
    // A zero burst count is treated as a single beat all the way to the controller.
    assign s.burst_count = (sel_bc == '0) ? BC_ONE : sel_bc;
    assign s.read        = s_read;
    assign s.write       = s_write;

    assign m0.wait_request = (fwd_phase && !owner_q) ? s.wait_request : 1'b1;
    assign m1.wait_request = (fwd_phase &&  owner_q) ? s.wait_request : 1'b1;

    // Valids outside a read phase are dropped; they carry no owner.
    assign m0.read_data       = s.read_data;
    assign m1.read_data       = s.read_data;
    assign m0.read_data_valid = s.read_data_valid && rd_phase && !owner_q;
    assign m1.read_data_valid = s.read_data_valid && rd_phase &&  owner_q;

    assign owner     = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sdram_avl_arbiter.sv
// Directed self-checking bench for sdram_avl_arbiter: burst reads/writes, ties, stalls, resets.
module tb_sdram_avl_arbiter;

    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_RD_CMD  = 2'd2;
    localparam logic [1:0] ST_RD_WAIT = 2'd3;

    logic       clk;
    logic       rst;
    logic [1:0] owner;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    sdram_avl_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m0_if ();
    sdram_avl_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m1_if ();
    sdram_avl_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) s_if ();

    sdram_avl_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if.slave),
        .m1        (m1_if.slave),
        .s         (s_if.master),
        .owner     (owner),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_if.address = '0; m0_if.read = 1'b0; m0_if.write = 1'b0;
        m0_if.write_data = '0; m0_if.byte_enable = '1; m0_if.burst_count = '0;
        m1_if.address = '0; m1_if.read = 1'b0; m1_if.write = 1'b0;
        m1_if.write_data = '0; m1_if.byte_enable = '1; m1_if.burst_count = '0;
        s_if.read_data = '0; s_if.read_data_valid = 1'b0; s_if.wait_request = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_owner", owner, 2'b00);
        check("rst_s_read", s_if.read, 1'b0);
        check("rst_s_write", s_if.write, 1'b0);
        check("rst_m0_wait", m0_if.wait_request, 1'b1);
        check("rst_m1_wait", m1_if.wait_request, 1'b1);
        check("rst_m0_valid", m0_if.read_data_valid, 1'b0);

        // 1: M0 read, burst 4
        m0_if.address = 22'h100; m0_if.burst_count = 5'd4; m0_if.read = 1'b1;
        settle();
        check("t1_idle_no_fwd", s_if.read, 1'b0);
        check("t1_idle_m0_wait", m0_if.wait_request, 1'b1);
        tick();
        check("t1_state_rdcmd", state_dbg, ST_RD_CMD);
        check("t1_owner", owner, 2'b01);
        check("t1_s_read", s_if.read, 1'b1);
        check("t1_s_addr", s_if.address, 22'h100);
        check("t1_s_bc", s_if.burst_count, 5'd4);
        check("t1_m0_wait", m0_if.wait_request, 1'b0);
        check("t1_m1_wait", m1_if.wait_request, 1'b1);
        tick();
        m0_if.read = 1'b0;
        settle();
        check("t1_state_rdwait", state_dbg, ST_RD_WAIT);
        check("t1_rdwait_s_read", s_if.read, 1'b0);
        check("t1_rdwait_m0_wait", m0_if.wait_request, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                s_if.read_data_valid = 1'b0;
                settle();
                check("t1_gap_m0_valid", m0_if.read_data_valid, 1'b0);
                tick();
                check("t1_gap_state", state_dbg, ST_RD_WAIT);
            end
            s_if.read_data = 32'hA000_0000 + 32'(i);
            exp_q.push_back(32'hA000_0000 + 32'(i));
            s_if.read_data_valid = 1'b1;
            settle();
            check("t1_m0_valid", m0_if.read_data_valid, 1'b1);
            check("t1_m1_valid", m1_if.read_data_valid, 1'b0);
            check("t1_m0_data", m0_if.read_data, exp_q.pop_front());
            check("t1_owner_beat", owner, 2'b01);
            tick();
        end
        s_if.read_data_valid = 1'b0;
        settle();
        check("t1_done_state", state_dbg, ST_IDLE);
        check("t1_done_owner", owner, 2'b00);
        // stray valid in IDLE is dropped
        s_if.read_data_valid = 1'b1;
        settle();
        check("t1_stray_m0", m0_if.read_data_valid, 1'b0);
        check("t1_stray_m1", m1_if.read_data_valid, 1'b0);
        tick();
        check("t1_stray_state", state_dbg, ST_IDLE);
        s_if.read_data_valid = 1'b0;

        // 2: simultaneous writes from reset, burst 2 each
        do_reset();
        m0_if.write = 1'b1; m0_if.burst_count = 5'd2; m0_if.write_data = 32'h1111_0001;
        m1_if.write = 1'b1; m1_if.burst_count = 5'd2; m1_if.write_data = 32'h2222_0001;
        settle();
        check("t2_idle_s_write", s_if.write, 1'b0);
        check("t2_idle_m0_wait", m0_if.wait_request, 1'b1);
        tick();
        check("t2_state", state_dbg, ST_WRITE);
        check("t2_owner_m0", owner, 2'b01);
        check("t2_s_write", s_if.write, 1'b1);
        check("t2_s_wdata0", s_if.write_data, 32'h1111_0001);
        check("t2_m0_wait", m0_if.wait_request, 1'b0);
        check("t2_m1_wait", m1_if.wait_request, 1'b1);
        tick();
        m0_if.write_data = 32'h1111_0002;
        settle();
        check("t2_mid_state", state_dbg, ST_WRITE);
        check("t2_s_wdata1", s_if.write_data, 32'h1111_0002);
        tick();
        m0_if.write = 1'b0;
        settle();
        check("t2_bubble_state", state_dbg, ST_IDLE);
        check("t2_bubble_owner", owner, 2'b00);
        check("t2_bubble_m1_wait", m1_if.wait_request, 1'b1);
        tick();
        check("t2_owner_m1", owner, 2'b10);
        check("t2_m1_wdata", s_if.write_data, 32'h2222_0001);
        check("t2_m1_wait_open", m1_if.wait_request, 1'b0);
        check("t2_m0_wait_closed", m0_if.wait_request, 1'b1);
        tick();
        tick();
        m1_if.write = 1'b0;
        settle();
        check("t2_m1_done", state_dbg, ST_IDLE);
        m0_if.write = 1'b1; m0_if.burst_count = 5'd1;
        m1_if.write = 1'b1; m1_if.burst_count = 5'd1;
        settle();
        tick();
        check("t2_tie2_m0", owner, 2'b01);
        tick();
        m0_if.write = 1'b0;
        settle();
        tick();
        check("t2_tie2_then_m1", owner, 2'b10);
        tick();
        m1_if.write = 1'b0;
        settle();
        check("t2_end_state", state_dbg, ST_IDLE);

        // 3: M1 write burst 3 with 5 stall cycles per beat, M0 waiting
        m1_if.write = 1'b1; m1_if.burst_count = 5'd3; m1_if.write_data = 32'h3333_0000;
        s_if.wait_request = 1'b1;
        settle();
        tick();
        check("t3_owner", owner, 2'b10);
        check("t3_state", state_dbg, ST_WRITE);
        m0_if.read = 1'b1; m0_if.burst_count = 5'd1; m0_if.address = 22'h200;
        settle();
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 5; c++) begin
                check("t3_stall_m1_wait", m1_if.wait_request, 1'b1);
                check("t3_stall_m0_wait", m0_if.wait_request, 1'b1);
                check("t3_stall_s_write", s_if.write, 1'b1);
                check("t3_stall_owner", owner, 2'b10);
                tick();
            end
            s_if.wait_request = 1'b0;
            settle();
            check("t3_beat_m1_wait", m1_if.wait_request, 1'b0);
            check("t3_beat_m0_wait", m0_if.wait_request, 1'b1);
            tick();
            s_if.wait_request = 1'b1;
            if (b == 2) m1_if.write = 1'b0;
            settle();
        end
        check("t3_done_state", state_dbg, ST_IDLE);
        check("t3_done_m0_wait", m0_if.wait_request, 1'b1);
        tick();
        check("t3_m0_owner", owner, 2'b01);
        check("t3_m0_rdcmd", state_dbg, ST_RD_CMD);
        check("t3_m0_addr", s_if.address, 22'h200);
        check("t3_m0_wait_slave", m0_if.wait_request, 1'b1);
        s_if.wait_request = 1'b0;
        settle();
        check("t3_m0_wait_open", m0_if.wait_request, 1'b0);
        tick();
        m0_if.read = 1'b0;
        s_if.read_data = 32'h3C3C_3C3C; s_if.read_data_valid = 1'b1;
        settle();
        check("t3_m0_valid", m0_if.read_data_valid, 1'b1);
        tick();
        s_if.read_data_valid = 1'b0;
        settle();
        check("t3_end_state", state_dbg, ST_IDLE);

        // 4: read with burst count 0 behaves as a single beat
        m0_if.read = 1'b1; m0_if.burst_count = 5'd0;
        settle();
        tick();
        check("t4_state", state_dbg, ST_RD_CMD);
        check("t4_s_bc", s_if.burst_count, 5'd1);
        tick();
        m0_if.read = 1'b0;
        s_if.read_data_valid = 1'b1;
        settle();
        check("t4_m0_valid", m0_if.read_data_valid, 1'b1);
        tick();
        s_if.read_data_valid = 1'b0;
        settle();
        check("t4_done_state", state_dbg, ST_IDLE);
        check("t4_done_owner", owner, 2'b00);

        // 5: reset in RD_WAIT after 2 of 8 beats
        m1_if.read = 1'b1; m1_if.burst_count = 5'd8;
        settle();
        tick();
        check("t5_owner", owner, 2'b10);
        check("t5_s_bc", s_if.burst_count, 5'd8);
        tick();
        m1_if.read = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_if.read_data_valid = 1'b1;
            settle();
            check("t5_m1_valid", m1_if.read_data_valid, 1'b1);
            check("t5_m0_valid", m0_if.read_data_valid, 1'b0);
            tick();
        end
        check("t5_pre_rst_state", state_dbg, ST_RD_WAIT);
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
        settle();
        check("t5_rst_state", state_dbg, ST_IDLE);
        check("t5_rst_owner", owner, 2'b00);
        check("t5_rst_m0_wait", m0_if.wait_request, 1'b1);
        check("t5_rst_m1_wait", m1_if.wait_request, 1'b1);
        check("t5_late_m1_valid", m1_if.read_data_valid, 1'b0);
        tick();
        check("t5_late_state", state_dbg, ST_IDLE);
        check("t5_late_m1_valid2", m1_if.read_data_valid, 1'b0);
        s_if.read_data_valid = 1'b0;

        // 6: M0 pauses WRITE for 3 cycles mid-burst while M1 waits
        m0_if.write = 1'b1; m0_if.burst_count = 5'd3; m0_if.write_data = 32'h6666_0001;
        m1_if.write = 1'b1; m1_if.burst_count = 5'd1;
        settle();
        tick();
        check("t6_owner", owner, 2'b01);
        tick();
        m0_if.write = 1'b0;
        settle();
        for (int c = 0; c < 3; c++) begin
            check("t6_pause_s_write", s_if.write, 1'b0);
            check("t6_pause_state", state_dbg, ST_WRITE);
            check("t6_pause_m1_wait", m1_if.wait_request, 1'b1);
            check("t6_pause_owner", owner, 2'b01);
            tick();
        end
        m0_if.write = 1'b1;
        settle();
        check("t6_resume_s_write", s_if.write, 1'b1);
        check("t6_resume_m0_wait", m0_if.wait_request, 1'b0);
        tick();
        check("t6_beat2_state", state_dbg, ST_WRITE);
        tick();
        m0_if.write = 1'b0;
        settle();
        check("t6_done_state", state_dbg, ST_IDLE);
        tick();
        check("t6_m1_owner", owner, 2'b10);
        tick();
        m1_if.write = 1'b0;
        settle();
        check("t6_end_state", state_dbg, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
